uart_apb_sched: RTL and testbench
=================================

Name: uart_apb_sched

Overview:
APB master that sequences and shares the UART APB slave register block between two byte-stream TX requesters and one RX consumer. It polls STATUS and drains RX bytes into a one-entry output buffer. It pushes TX bytes from the requesters in round-robin order, only when the TX FIFO is not full. It programs CONFIG after reset and on request. It sits between the system fabric and the UART slave's APB port.

Parameters:
CFG_RESET, 8'h03, CONFIG value written after reset (8 data bits, no parity).
POLL_GAP, 4, idle cycles between STATUS polls when the previous poll found no work (1..255).
TIMEOUT, 32, maximum access-phase cycles waiting for m_pready before the transfer is aborted (2..255).

Ports:
pclk  in  1  clock
preset  in  1  asynchronous reset, active-high
m_paddr  out  4  APB address (CONFIG=0x0, TX=0x2, RX=0x3, STATUS=0x4)
m_psel  out  1  APB select
m_penable  out  1  APB enable
m_pwrite  out  1  APB direction (1=write)
m_pwdata  out  8  APB write data
m_prdata  in  8  APB read data; slave registers it, so it is valid the cycle after access completion
m_pready  in  1  APB ready
req0_valid / req1_valid  in  1  TX byte offered by requester 0 / 1
req0_data / req1_data  in  8  TX byte
req0_ready / req1_ready  out  1  one-cycle pulse: byte accepted
rx_valid_o  out  1  received byte available
rx_data_o  out  8  received byte
rx_ready_i  in  1  consumer accepts the byte
cfg_data  in  8  new CONFIG value, sampled with cfg_req
cfg_req  in  1  pulse: request a CONFIG rewrite
cfg_busy  out  1  a CONFIG write is pending or in progress
ovr_o  out  1  sticky: STATUS[2] RX_OVERRUN was seen; cleared only by reset
err_o  out  1  one-cycle pulse on APB timeout

Behaviour:
- Reset values:
  - all APB outputs 0.
  - req*_ready, rx_valid_o, ovr_o, err_o 0; rx_data_o 8'h00.
  - cfg_busy 1, because the CONFIG write of CFG_RESET is pending.
  - round-robin pointer = requester 0.
  - FSM = DECIDE.
- Reset mid-transfer drops psel/penable immediately. There is no bus recovery.
- Every APB transfer uses two states:
  - SETUP: psel=1, penable=0, addr/pwrite/pwdata valid.
  - ACCESS: psel=1, penable=1, held until the pclk edge where m_pready=1; outputs return to 0 the next cycle.
  - A write is 2 cycles minimum.
  - A read adds a CAPTURE cycle after completion, in which m_prdata is sampled. A read is 3 cycles minimum.
- Timeout:
  - A counter runs in ACCESS.
  - On reaching TIMEOUT cycles without pready: drop the bus, pulse err_o, go to DECIDE.
  - The aborted transfer is discarded: no req_ready pulse, no RX capture, and a pending CONFIG stays pending.
- FSM states: DECIDE, GAP, CFG_S/CFG_A, POLL_S/POLL_A/POLL_C, RX_S/RX_A/RX_C, TX_S/TX_A.
- DECIDE priority:
  1. Pending CONFIG → CFG.
  2. Otherwise → POLL.
- CFG: write the latched value to 0x0. cfg_busy falls the cycle after completion. A cfg_req while busy overwrites the latched value; a single write results.
- POLL: read 0x4. In POLL_C, latch STATUS and set ovr_o if bit2=1. Then take exactly one action:
  - RX if STATUS[1]=1 and rx_valid_o=0.
  - Else TX if some req*_valid=1 and STATUS[4]=0.
  - Else GAP for POLL_GAP cycles, then DECIDE.
- RX:
  - Read 0x3; in RX_C load rx_data_o and set rx_valid_o.
  - rx_valid_o clears on the cycle with rx_valid_o & rx_ready_i.
  - If STATUS[1]=1 while rx_valid_o=1, no RX read is issued (backpressure); the UART flags overrun.
- TX:
  - Grant: the requester at the round-robin pointer if valid, else the other one.
  - Grant is evaluated in POLL_C; the data is latched into m_pwdata at TX_S entry.
  - Write 0x2; the granted req*_ready pulses in the cycle after write completion.
  - The pointer then moves to the requester that was not granted.
  - One byte per poll, so TX_FULL is always re-checked before each write.
- After RX or TX completion → DECIDE with no gap.
- Requesters must hold valid/data stable until ready.

Test Plan:
- Reset release, pready tied 1 → first transfer is a write of 8'h03 to 0x0 (2 cycles); then cfg_busy=0; then a read of 0x4 follows.
- STATUS=8'h02, RX reg=8'hA5, rx_ready_i=0 → rx_valid_o=1, rx_data_o=A5. A later poll with STATUS[1]=1 issues no 0x3 read. Assert rx_ready_i → rx_valid_o clears, and the next poll reads 0x3.
- Both requesters valid (0x11, 0x22), STATUS=0x01 → writes to 0x2 are 0x11, 0x22, 0x11… alternating, each with a matching ready pulse.
- STATUS=0x10 with req0 valid → no 0x2 write; polls repeat separated by POLL_GAP idle cycles. Clear bit4 → 0x2 write, then req0_ready pulse.
- pready held 0 → after TIMEOUT access cycles the bus drops, err_o pulses once, and no ready pulse occurs.
- cfg_req with 0x0C during an in-flight TX write → TX completes, next transfer writes 0x0C to 0x0. STATUS=0x04 → ovr_o=1 and stays 1.

Source files
------------

// File: rtl/uart_apb_sched.sv
// rtl/uart_apb_sched.sv - APB master sharing the UART register block between two TX requesters and one RX consumer
module uart_apb_sched #(
  parameter logic [7:0]  CFG_RESET = 8'h03,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic       pclk,
  input  logic       preset,
  output logic [3:0] m_paddr,
  output logic       m_psel,
  output logic       m_penable,
  output logic       m_pwrite,
  output logic [7:0] m_pwdata,
  input  logic [7:0] m_prdata,
  input  logic       m_pready,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  logic       rx_ready_i,
  input  logic [7:0] cfg_data,
  input  logic       cfg_req,
  output logic       cfg_busy,
  output logic       ovr_o,
  output logic       err_o
);

  localparam logic [3:0] ADDR_CFG  = 4'h0;
  localparam logic [3:0] ADDR_TX   = 4'h2;
  localparam logic [3:0] ADDR_RX   = 4'h3;
  localparam logic [3:0] ADDR_STAT = 4'h4;
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    ST_DECIDE, ST_GAP,
    ST_CFG_S, ST_CFG_A,
    ST_POLL_S, ST_POLL_A, ST_POLL_C,
    ST_RX_S, ST_RX_A, ST_RX_C,
    ST_TX_S, ST_TX_A
  } state_t;

  state_t     state_q, state_d;
  logic       rr_q, rr_d;
  logic       grant_q, grant_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] cfg_val_q, cfg_val_d;
  logic       cfg_pend_q, cfg_pend_d;
  logic       cfg_again_q, cfg_again_d;
  logic [7:0] status_q, status_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       ovr_q, ovr_d;
  logic       err_q, err_d;
  logic [1:0] rdy_q, rdy_d;
  logic [7:0] tmo_q, tmo_d;
  logic [7:0] gap_q, gap_d;
  logic       gnt;

  // Round-robin grant: the pointed-to requester if it is offering, else the other one
  always_comb begin
    gnt = rr_q ? req1_valid : ~req0_valid;
  end

  // Next-state, bus drive and bookkeeping for the whole scheduler
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    wdata_d     = wdata_q;
    cfg_val_d   = cfg_val_q;
    cfg_pend_d  = cfg_pend_q;
    cfg_again_d = cfg_again_q;
    status_d    = status_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    ovr_d       = ovr_q;
    err_d       = 1'b0;
    rdy_d       = 2'b00;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    m_psel      = 1'b0;
    m_penable   = 1'b0;
    m_pwrite    = 1'b0;
    m_paddr     = 4'h0;

    if (cfg_req) begin
      cfg_val_d  = cfg_data;
      cfg_pend_d = 1'b1;
    end
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      ST_DECIDE: begin
        if (cfg_pend_q) begin
          state_d     = ST_CFG_S;
          wdata_d     = cfg_val_q;
          cfg_again_d = cfg_req;
        end else begin
          state_d = ST_POLL_S;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) state_d = ST_DECIDE;
        else               gap_d   = gap_q - 8'd1;
      end
      ST_CFG_S, ST_CFG_A: begin
        m_psel    = 1'b1;
        m_pwrite  = 1'b1;
        m_paddr   = ADDR_CFG;
        // A request landing while the value is already on the bus must not be lost
        if (cfg_req) cfg_again_d = 1'b1;
        if (state_q == ST_CFG_S) begin
          state_d = ST_CFG_A;
        end else begin
          m_penable = 1'b1;
          if (m_pready) begin
            cfg_pend_d = cfg_again_q | cfg_req;
            state_d    = ST_DECIDE;
          end
        end
      end
      ST_POLL_S: begin
        m_psel  = 1'b1;
        m_paddr = ADDR_STAT;
        state_d = ST_POLL_A;
      end
      ST_POLL_A: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        m_paddr   = ADDR_STAT;
        if (m_pready) state_d = ST_POLL_C;
      end
      ST_POLL_C: begin
        status_d = m_prdata;
        if (m_prdata[2]) ovr_d = 1'b1;
        if (m_prdata[1] && !rx_valid_q) begin
          state_d = ST_RX_S;
        end else if ((req0_valid || req1_valid) && !m_prdata[4]) begin
          state_d = ST_TX_S;
          grant_d = gnt;
          wdata_d = gnt ? req1_data : req0_data;
        end else begin
          state_d = ST_GAP;
          gap_d   = GAP_LAST;
        end
      end
      ST_RX_S: begin
        m_psel  = 1'b1;
        m_paddr = ADDR_RX;
        state_d = ST_RX_A;
      end
      ST_RX_A: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        m_paddr   = ADDR_RX;
        if (m_pready) state_d = ST_RX_C;
      end
      ST_RX_C: begin
        rx_data_d  = m_prdata;
        rx_valid_d = 1'b1;
        state_d    = ST_DECIDE;
      end
      ST_TX_S: begin
        m_psel   = 1'b1;
        m_pwrite = 1'b1;
        m_paddr  = ADDR_TX;
        state_d  = ST_TX_A;
      end
      ST_TX_A: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        m_pwrite  = 1'b1;
        m_paddr   = ADDR_TX;
        if (m_pready) begin
          rdy_d[grant_q] = 1'b1;
          rr_d           = ~grant_q;
          state_d        = ST_DECIDE;
        end
      end
      default: state_d = ST_DECIDE;
    endcase

    // Any access phase that outlives TIMEOUT cycles is abandoned with no side effects
    if (m_penable && !m_pready) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_DECIDE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end else if (!m_penable) begin
      tmo_d = 8'd0;
    end

    m_pwdata = (m_psel && m_pwrite) ? wdata_q : 8'h00;
  end

  // State and datapath registers; CONFIG write is pending out of reset
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_DECIDE;
      rr_q        <= 1'b0;
      grant_q     <= 1'b0;
      wdata_q     <= 8'h00;
      cfg_val_q   <= CFG_RESET;
      cfg_pend_q  <= 1'b1;
      cfg_again_q <= 1'b0;
      status_q    <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      ovr_q       <= 1'b0;
      err_q       <= 1'b0;
      rdy_q       <= 2'b00;
      tmo_q       <= 8'd0;
      gap_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      wdata_q     <= wdata_d;
      cfg_val_q   <= cfg_val_d;
      cfg_pend_q  <= cfg_pend_d;
      cfg_again_q <= cfg_again_d;
      status_q    <= status_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
      rdy_q       <= rdy_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
    end
  end

  assign req0_ready = rdy_q[0];
  assign req1_ready = rdy_q[1];
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign cfg_busy   = cfg_pend_q;
  assign ovr_o      = ovr_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_apb_sched.sv
// tb/tb_uart_apb_sched.sv - directed self-checking bench for uart_apb_sched
module tb_uart_apb_sched;
  localparam int TIMEOUT  = 32;
  localparam int POLL_GAP = 4;

  logic       pclk = 1'b0;
  logic       preset;
  logic [3:0] m_paddr;
  logic       m_psel, m_penable, m_pwrite;
  logic [7:0] m_pwdata;
  logic [7:0] m_prdata = 8'h00;
  logic       m_pready;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       rx_valid_o, rx_ready_i;
  logic [7:0] rx_data_o;
  logic [7:0] cfg_data;
  logic       cfg_req, cfg_busy, ovr_o, err_o;

  logic [7:0] status_reg, rx_reg;

  typedef struct {
    logic [3:0] a;
    logic       w;
    logic [7:0] d;
    int         st;
    int         cp;
  } rec_t;

  rec_t log_q[$];
  rec_t mon_r;
  int   cyc = 0, cur_st = 0, acc_run = 0;
  int   cnt_r0 = 0, cnt_r1 = 0, cnt_err = 0;
  int   rd_idx = 0;
  int   n_checks = 0, n_errors = 0;

  uart_apb_sched #(.CFG_RESET(8'h03), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .m_paddr(m_paddr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i),
    .cfg_data(cfg_data), .cfg_req(cfg_req), .cfg_busy(cfg_busy),
    .ovr_o(ovr_o), .err_o(err_o)
  );

  always #5 pclk = ~pclk;

  // UART slave model plus transfer log and pulse counters
  always @(posedge pclk) begin
    cyc = cyc + 1;
    if (m_psel && !m_penable) begin
      cur_st  = cyc;
      acc_run = 0;
    end
    if (m_psel && m_penable) acc_run = acc_run + 1;
    if (m_psel && m_penable && m_pready) begin
      mon_r.a  = m_paddr;
      mon_r.w  = m_pwrite;
      mon_r.d  = m_pwrite ? m_pwdata : ((m_paddr == 4'h4) ? status_reg : rx_reg);
      mon_r.st = cur_st;
      mon_r.cp = cyc;
      log_q.push_back(mon_r);
      if (!m_pwrite) m_prdata <= (m_paddr == 4'h4) ? status_reg : rx_reg;
    end
    if (req0_ready) cnt_r0 = cnt_r0 + 1;
    if (req1_ready) cnt_r1 = cnt_r1 + 1;
    if (err_o)      cnt_err = cnt_err + 1;
  end

  task automatic tick();
    @(negedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t rec_at(input int idx);
    rec_t r;
    r = '{a: 4'h0, w: 1'b0, d: 8'h00, st: 0, cp: 0};
    if (idx >= 0 && idx < log_q.size()) r = log_q[idx];
    return r;
  endfunction

  function automatic int count_addr(input int from, input logic [3:0] a);
    int n = 0;
    for (int i = from; i < log_q.size(); i++) if (log_q[i].a == a) n++;
    return n;
  endfunction

  task automatic wait_next(input string tag, output int idx);
    int g = 0;
    idx = -1;
    while (rd_idx >= log_q.size() && g < 400) begin
      tick();
      g++;
    end
    if (rd_idx < log_q.size()) begin
      idx = rd_idx;
      rd_idx++;
    end
    chk({tag, "_seen"}, (idx >= 0), 1);
  endtask

  task automatic wait_match(input string tag, input logic [3:0] a, input logic w, output int idx);
    int g = 0;
    idx = -1;
    while (idx < 0 && g < 400) begin
      if (rd_idx < log_q.size()) begin
        if (log_q[rd_idx].a == a && log_q[rd_idx].w == w) idx = rd_idx;
        rd_idx++;
      end else begin
        tick();
        g++;
      end
    end
    chk({tag, "_seen"}, (idx >= 0), 1);
  endtask

  task automatic wait_tx_setup();
    int g = 0;
    while (!(m_psel && !m_penable && m_pwrite && m_paddr == 4'h2) && g < 400) begin
      tick();
      g++;
    end
    chk("tx_setup_seen", (g < 400), 1);
  endtask

  initial begin
    int   idx, e1, e2, base, r0s, r1s, es, g;
    rec_t r;
    preset = 1'b1; m_pready = 1'b1; status_reg = 8'h00; rx_reg = 8'hA5;
    rx_ready_i = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; cfg_req = 1'b0; cfg_data = 8'h00;
    tick(); tick();

    chk("rst_psel", m_psel, 0);
    chk("rst_penable", m_penable, 0);
    chk("rst_pwrite", m_pwrite, 0);
    chk("rst_paddr", m_paddr, 0);
    chk("rst_pwdata", m_pwdata, 0);
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_data", rx_data_o, 8'h00);
    chk("rst_ovr_err", {ovr_o, err_o}, 0);
    chk("rst_cfg_busy", cfg_busy, 1);

    preset = 1'b0;
    wait_next("cfg0", idx);
    r = rec_at(idx);
    chk("cfg0_addr_wr", {r.a, r.w}, {4'h0, 1'b1});
    chk("cfg0_data", r.d, 8'h03);
    chk("cfg0_cycles", r.cp - r.st + 1, 2);
    chk("cfg0_busy_low", cfg_busy, 0);
    wait_next("poll0", idx);
    r = rec_at(idx);
    chk("poll0_addr_rd", {r.a, r.w}, {4'h4, 1'b0});

    // RX drain with back-pressure
    status_reg = 8'h02;
    wait_match("rx1", 4'h3, 1'b0, idx);
    tick(); tick();
    chk("rx1_valid", rx_valid_o, 1);
    chk("rx1_data", rx_data_o, 8'hA5);
    rx_reg = 8'h5A;
    base = log_q.size();
    repeat (40) tick();
    chk("rx_bp_no_read", count_addr(base, 4'h3), 0);
    chk("rx_bp_polls", (count_addr(base, 4'h4) >= 2), 1);
    chk("rx_bp_hold_valid", rx_valid_o, 1);
    rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
    chk("rx1_cleared", rx_valid_o, 0);
    wait_match("rx2", 4'h3, 1'b0, idx);
    status_reg = 8'h00;
    tick(); tick();
    chk("rx2_data", rx_data_o, 8'h5A);
    rx_ready_i = 1'b1; tick(); rx_ready_i = 1'b0;
    chk("rx2_cleared", rx_valid_o, 0);

    // Round-robin TX between both requesters
    req0_data = 8'h11; req1_data = 8'h22;
    req0_valid = 1'b1; req1_valid = 1'b1; status_reg = 8'h01;
    r0s = cnt_r0; r1s = cnt_r1;
    for (int i = 0; i < 4; i++) begin
      wait_match("rr_tx", 4'h2, 1'b1, idx);
      r = rec_at(idx);
      chk("rr_tx_data", r.d, (i % 2 == 0) ? 8'h11 : 8'h22);
      chk("rr_tx_ready", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    tick(); tick();
    chk("rr_r0_pulses", cnt_r0 - r0s, 2);
    chk("rr_r1_pulses", cnt_r1 - r1s, 2);

    // TX_FULL holds off writes; polls spaced by the idle gap
    status_reg = 8'h10;
    wait_match("full_p0", 4'h4, 1'b0, idx);
    req0_data = 8'h33; req0_valid = 1'b1;
    r0s = cnt_r0;
    base = log_q.size();
    wait_match("full_p1", 4'h4, 1'b0, e1);
    wait_match("full_p2", 4'h4, 1'b0, e2);
    g = rec_at(e2).st - rec_at(e1).cp - 1;
    chk("full_gap_idle", (g >= POLL_GAP && g <= POLL_GAP + 2), 1);
    chk("full_no_tx", count_addr(base, 4'h2), 0);
    chk("full_no_ready", cnt_r0 - r0s, 0);
    status_reg = 8'h00;
    wait_match("full_tx", 4'h2, 1'b1, idx);
    chk("full_tx_data", rec_at(idx).d, 8'h33);
    chk("full_tx_ready", {req1_ready, req0_ready}, 2'b01);
    req0_valid = 1'b0;

    // Timeout on a TX write
    req1_data = 8'h44; req1_valid = 1'b1; status_reg = 8'h01;
    wait_tx_setup();
    m_pready = 1'b0;
    es = cnt_err; r1s = cnt_r1;
    g = 0;
    while (cnt_err == es && g < 200) begin
      tick();
      g++;
    end
    chk("tmo_err_seen", (cnt_err != es), 1);
    chk("tmo_access_len", acc_run, TIMEOUT);
    chk("tmo_bus_dropped", m_penable, 0);
    chk("tmo_no_ready", cnt_r1 - r1s, 0);
    m_pready = 1'b1;
    wait_match("tmo_retry", 4'h2, 1'b1, idx);
    chk("tmo_retry_data", rec_at(idx).d, 8'h44);
    chk("tmo_retry_ready", req1_ready, 1);
    req1_valid = 1'b0;
    tick(); tick();
    chk("tmo_err_once", cnt_err - es, 1);
    chk("tmo_ovr_clear", ovr_o, 0);

    // CONFIG request during an in-flight TX write
    req0_data = 8'h55; req0_valid = 1'b1;
    wait_tx_setup();
    chk("cfg1_busy_before", cfg_busy, 0);
    cfg_data = 8'h0C; cfg_req = 1'b1;
    tick();
    cfg_req = 1'b0;
    chk("cfg1_busy", cfg_busy, 1);
    wait_match("cfg1_tx", 4'h2, 1'b1, idx);
    chk("cfg1_tx_data", rec_at(idx).d, 8'h55);
    chk("cfg1_tx_ready", req0_ready, 1);
    req0_valid = 1'b0; status_reg = 8'h00;
    wait_next("cfg1_wr", idx);
    r = rec_at(idx);
    chk("cfg1_addr_wr", {r.a, r.w}, {4'h0, 1'b1});
    chk("cfg1_data", r.d, 8'h0C);
    chk("cfg1_busy_low", cfg_busy, 0);

    // Sticky overrun flag
    status_reg = 8'h04;
    wait_match("ovr_p0", 4'h4, 1'b0, idx);
    tick(); tick();
    chk("ovr_set", ovr_o, 1);
    status_reg = 8'h00;
    wait_match("ovr_p1", 4'h4, 1'b0, idx);
    wait_match("ovr_p2", 4'h4, 1'b0, idx);
    tick(); tick();
    chk("ovr_sticky", ovr_o, 1);
    chk("end_err_count", cnt_err - es, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
